// File: rtl/uut_test_pkg.sv
// Shared types and constants for the UUT test sequencer.
package uut_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RST_UUT,
        ST_RUN,
        ST_CAPTURE,
        ST_EMIT
    } state_e;

    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

endpackage

// File: rtl/uut_result_serializer.sv
// Parallel-load result record, shifted out MSB-first one byte per handshake.
module uut_result_serializer #(
    parameter int unsigned REC_BYTES = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [REC_BYTES*8-1:0] rec_i,
    input  logic                   out_ready_i,
    output logic                   out_valid_o,
    output logic [7:0]             out_byte_o,
    output logic                   done_o
);

    localparam int unsigned RW = REC_BYTES * 8;
    localparam int unsigned CW = $clog2(REC_BYTES + 1);

    logic [RW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          valid_q, valid_d;
    logic          xfer;

    assign xfer        = valid_q && out_ready_i;
    assign done_o      = xfer && (rem_q == CW'(1));
    assign out_valid_o = valid_q;
    assign out_byte_o  = shreg_q[RW-1 -: 8];

    // Next-state: load a fresh record or shift one byte out per transfer
    always_comb begin
        shreg_d = shreg_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        if (load_i) begin
            shreg_d = rec_i;
            rem_d   = CW'(REC_BYTES);
            valid_d = 1'b1;
        end else if (xfer) begin
            shreg_d = shreg_q << 8;
            rem_d   = rem_q - 1'b1;
            if (rem_q == CW'(1)) begin
                valid_d = 1'b0;
            end
        end
    end

    // Serializer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uut_test_sequencer.sv
// Test sequencer: loads UUT input vectors from a byte stream, pulses the UUT
// reset, times the run (with timeout) and emits a status/count/result record.
module uut_test_sequencer
    import uut_test_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 3,
    parameter int unsigned INPUT_SIZE  = 32,
    parameter int unsigned OUTPUT_SIZE = 32,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned TIMEOUT     = 2**20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [7:0]                       in_byte,
    output logic                             rst_uut,
    input  logic                             end_uut,
    output logic [NUM_INPUTS*INPUT_SIZE-1:0] input_to_UUT,
    input  logic [OUTPUT_SIZE-1:0]           output_from_UUT,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [7:0]                       out_byte,
    output logic                             busy,
    output logic                             timeout_err,
    output logic [CNT_WIDTH-1:0]             cycle_count
);

    localparam int unsigned IN_W      = NUM_INPUTS * INPUT_SIZE;
    localparam int unsigned NB        = IN_W / 8;
    localparam int unsigned BC_W      = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned REC_BYTES = 1 + CNT_WIDTH / 8 + OUTPUT_SIZE / 8;

    if (NUM_INPUTS < 1 || NUM_INPUTS > 8) begin : g_bad_num_inputs
        $error("NUM_INPUTS must be in 1..8");
    end
    if (INPUT_SIZE == 0 || (INPUT_SIZE % 8) != 0) begin : g_bad_input_size
        $error("INPUT_SIZE must be a non-zero multiple of 8");
    end
    if (OUTPUT_SIZE == 0 || (OUTPUT_SIZE % 8) != 0) begin : g_bad_output_size
        $error("OUTPUT_SIZE must be a non-zero multiple of 8");
    end
    if (CNT_WIDTH == 0 || (CNT_WIDTH % 8) != 0) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be a non-zero multiple of 8");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("RST_CYCLES must be at least 1");
    end
    if (CNT_WIDTH < 64 && 64'(TIMEOUT) >= (64'd1 << CNT_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT must be below 2**CNT_WIDTH");
    end
    if (CNT_WIDTH < 64 && 64'(RST_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_rst_fit
        $error("RST_CYCLES does not fit the cycle counter");
    end

    state_e                state_q, state_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IN_W-1:0]       in_q, in_d;
    logic [CNT_WIDTH-1:0]  ccount_q, ccount_d;
    logic                  terr_q, terr_d;

    logic                  in_xfer;
    logic                  last_byte;
    logic                  rst_done;
    logic                  at_timeout;
    logic                  ser_load;
    logic [REC_BYTES*8-1:0] rec_word;
    logic                  ser_valid;
    logic                  ser_done;

    assign in_xfer    = (state_q == ST_LOAD) && in_valid;
    assign last_byte  = (byte_cnt_q == BC_W'(NB - 1));
    assign rst_done   = (cnt_q == CNT_WIDTH'(RST_CYCLES - 1));
    assign at_timeout = (cnt_q == CNT_WIDTH'(TIMEOUT));

    assign input_to_UUT = in_q;
    assign cycle_count  = ccount_q;
    assign timeout_err  = terr_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_LOAD;
            ST_LOAD:    if (in_xfer && last_byte) state_d = ST_RST_UUT;
            ST_RST_UUT: if (rst_done) state_d = ST_RUN;
            ST_RUN:     if (end_uut || at_timeout) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_EMIT;
            ST_EMIT:    if (ser_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode; status outputs are forced inactive while rst is held
    always_comb begin
        in_ready  = (state_q == ST_LOAD) && !rst;
        busy      = (state_q != ST_IDLE) && !rst;
        rst_uut   = rst || !((state_q == ST_LOAD) || (state_q == ST_RUN));
        out_valid = ser_valid && !rst;
        ser_load  = (state_q == ST_CAPTURE);
        rec_word  = {(terr_q ? STATUS_TIMEOUT : STATUS_OK), ccount_q, output_from_UUT};
    end

    // Datapath next-state: byte shifter, shared reset/run counter, result capture
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        cnt_d      = cnt_q;
        in_d       = in_q;
        ccount_d   = ccount_q;
        terr_d     = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    terr_d     = 1'b0;
                    byte_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (in_xfer) begin
                    in_d = (in_q << 8) | IN_W'(in_byte);
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        cnt_d      = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_RST_UUT: begin
                cnt_d = rst_done ? '0 : cnt_q + 1'b1;
            end
            ST_RUN: begin
                // end_uut takes priority so a completion on the timeout cycle is a pass
                if (end_uut) begin
                    ccount_d = cnt_q;
                end else if (at_timeout) begin
                    terr_d   = 1'b1;
                    ccount_d = CNT_WIDTH'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            cnt_q      <= '0;
            in_q       <= '0;
            ccount_q   <= '0;
            terr_q     <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            cnt_q      <= cnt_d;
            in_q       <= in_d;
            ccount_q   <= ccount_d;
            terr_q     <= terr_d;
        end
    end

    uut_result_serializer #(
        .REC_BYTES (REC_BYTES)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ser_load),
        .rec_i       (rec_word),
        .out_ready_i (out_ready),
        .out_valid_o (ser_valid),
        .out_byte_o  (out_byte),
        .done_o      (ser_done)
    );

endmodule

// File: tb/tb_uut_test_sequencer.sv
// Scoreboard bench for uut_test_sequencer with directed vectors.
module tb_uut_test_sequencer;

    localparam int unsigned NUM_INPUTS  = 3;
    localparam int unsigned INPUT_SIZE  = 16;
    localparam int unsigned OUTPUT_SIZE = 16;
    localparam int unsigned CNT_WIDTH   = 16;
    localparam int unsigned RST_CYCLES  = 4;
    localparam int unsigned TIMEOUT     = 100;

    logic                             clk;
    logic                             rst;
    logic                             start;
    logic                             in_valid;
    logic                             in_ready;
    logic [7:0]                       in_byte;
    logic                             rst_uut;
    logic                             end_uut;
    logic [NUM_INPUTS*INPUT_SIZE-1:0] input_to_UUT;
    logic [OUTPUT_SIZE-1:0]           output_from_UUT;
    logic                             out_valid;
    logic                             out_ready;
    logic [7:0]                       out_byte;
    logic                             busy;
    logic                             timeout_err;
    logic [CNT_WIDTH-1:0]             cycle_count;

    uut_test_sequencer #(
        .NUM_INPUTS  (NUM_INPUTS),
        .INPUT_SIZE  (INPUT_SIZE),
        .OUTPUT_SIZE (OUTPUT_SIZE),
        .CNT_WIDTH   (CNT_WIDTH),
        .RST_CYCLES  (RST_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_byte         (in_byte),
        .rst_uut         (rst_uut),
        .end_uut         (end_uut),
        .input_to_UUT    (input_to_UUT),
        .output_from_UUT (output_from_UUT),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_byte        (out_byte),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .cycle_count     (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         ready_mode = 0;  // 0: always ready, 1: toggle, 2: stall 7 then toggle, 3: never

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_rec(input logic [39:0] r);
        for (int i = 0; i < 5; i++) exp_q.push_back(r[39-8*i -: 8]);
    endtask

    // out_ready driver
    initial begin : ready_drv
        int tcyc;
        int vcyc;
        tcyc = 0;
        vcyc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tcyc++;
            vcyc = out_valid ? vcyc + 1 : 0;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = tcyc[0];
                2:       out_ready = (vcyc <= 7) ? 1'b0 : vcyc[0];
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares each transferred byte against the scoreboard, and
    // checks that a stalled byte is held
    initial begin : monitor
        logic       stall_prev;
        logic [7:0] byte_prev;
        stall_prev = 1'b0;
        byte_prev  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_hold", {out_valid, out_byte}, {1'b1, byte_prev});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_byte);
                    end else begin
                        check("rec_byte", out_byte, exp_q.pop_front());
                    end
                end
                stall_prev = out_valid && !out_ready;
                byte_prev  = out_byte;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst_uut"},     rst_uut, 1'b1);
        check({tag, "_in_ready"},    in_ready, 1'b0);
        check({tag, "_out_valid"},   out_valid, 1'b0);
        check({tag, "_busy"},        busy, 1'b0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
        check({tag, "_out_byte"},    out_byte, 8'h00);
        check({tag, "_cycle_count"}, cycle_count, 16'h0000);
        check({tag, "_input"},       input_to_UUT, 48'h0);
    endtask

    task automatic start_test();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic load(input logic [47:0] v, input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                in_valid = 1'b0;
                in_byte  = 8'hEE;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_byte  = v[47-8*i -: 8];
            check("in_ready_load", in_ready, 1'b1);
            check("rst_uut_load", rst_uut, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic rst_pulse(input bit pulse_end);
        int n = 0;
        @(negedge clk);
        while (rst_uut && n < 20) begin
            n++;
            end_uut = pulse_end && (n == 2);
            @(negedge clk);
        end
        end_uut = 1'b0;
        check("rst_uut_len", n, RST_CYCLES);
    endtask

    // Entered at the negedge of RUN cycle 0; k < 0 means end_uut is never raised
    task automatic run_uut(input int k, input bit pulse_start);
        if (k < 0) return;
        for (int c = 1; c <= k; c++) begin
            @(posedge clk);
            #1;
            start = pulse_start && (c == 3);
        end
        start   = 1'b0;
        end_uut = 1'b1;
        @(posedge clk);
        #1;
        end_uut = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, expected 0", n);
        end
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic full_test(input logic [47:0] v, input bit gapped, input int k,
                             input bit pulse_end, input bit pulse_start);
        start_test();
        load(v, 6, gapped);
        check("input_to_UUT", input_to_UUT, v);
        rst_pulse(pulse_end);
        run_uut(k, pulse_start);
        wait_idle();
    endtask

    initial begin : main
        int n;
        rst             = 1'b1;
        start           = 1'b0;
        in_valid        = 1'b0;
        in_byte         = 8'h00;
        end_uut         = 1'b0;
        output_from_UUT = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Nominal
        ready_mode = 0;
        output_from_UUT = 16'hBEEF;
        push_rec(40'h00_0009_BEEF);
        full_test(48'h010203040506, 1'b0, 9, 1'b0, 1'b0);
        check("nom_timeout_err", timeout_err, 1'b0);
        check("nom_cycle_count", cycle_count, 16'd9);
        check("nom_out_valid_idle", out_valid, 1'b0);

        // in_valid while IDLE must not shift data
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_in_ignored", input_to_UUT, 48'h010203040506);

        // start during RUN and end_uut during RST_UUT are ignored
        push_rec(40'h00_000C_BEEF);
        full_test(48'h112233445566, 1'b0, 12, 1'b1, 1'b1);
        check("ign_cycle_count", cycle_count, 16'd12);

        // Timeout
        output_from_UUT = 16'h1234;
        push_rec(40'h01_0064_1234);
        full_test(48'h0A0B0C0D0E0F, 1'b0, -1, 1'b0, 1'b0);
        check("to_timeout_err", timeout_err, 1'b1);
        check("to_cycle_count", cycle_count, 16'd100);

        // end_uut on the timeout cycle is a success
        output_from_UUT = 16'hCAFE;
        push_rec(40'h00_0064_CAFE);
        full_test(48'h010203040506, 1'b0, 100, 1'b0, 1'b0);
        check("bnd_timeout_err", timeout_err, 1'b0);
        check("bnd_cycle_count", cycle_count, 16'd100);

        // Backpressure: toggling ready, gapped input
        ready_mode = 1;
        output_from_UUT = 16'hBEEF;
        push_rec(40'h00_0009_BEEF);
        full_test(48'h010203040506, 1'b1, 9, 1'b0, 1'b0);

        // Backpressure: 7-cycle stall then toggling
        ready_mode = 2;
        push_rec(40'h00_0009_BEEF);
        full_test(48'h010203040506, 1'b1, 9, 1'b0, 1'b0);
        ready_mode = 0;

        // Reset after 3 LOAD bytes
        start_test();
        load(48'hA1A2A3A4A5A6, 3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_load");
        rst = 1'b0;

        // Reset during EMIT with the record stalled
        ready_mode = 3;
        output_from_UUT = 16'h7777;
        start_test();
        load(48'h010203040506, 6, 1'b0);
        rst_pulse(1'b0);
        run_uut(9, 1'b0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("emit_reached", out_valid, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_emit");
        rst = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Fresh full test after the aborted ones
        output_from_UUT = 16'h5A5A;
        push_rec(40'h00_0014_5A5A);
        full_test(48'hF0E1D2C3B4A5, 1'b0, 20, 1'b0, 1'b0);
        check("final_cycle_count", cycle_count, 16'd20);
        check("final_timeout_err", timeout_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
